// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ctrl
//  Brief    : Pointer/count controller for a 2**W-deep FIFO built around an
//             external register file. Generates the write strobe, write/read
//             addresses, occupancy count, level flags and sticky error flags.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_ctrl #(
    parameter int W      = 2,   // address width, depth = 2**W
    parameter int AF_LVL = 3,   // almost-full threshold (1..D)
    parameter int AE_LVL = 1    // almost-empty threshold (0..D-1)
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         wr,
    input  logic         rd,
    input  logic         err_clr,
    output logic         wr_en,
    output logic [W-1:0] w_addr,
    output logic [W-1:0] r_addr,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic [W:0]   count,
    output logic         ovf,
    output logic         udf
);

    // Depth and thresholds expressed at the width of the occupancy counter
    localparam logic [W:0]   c_depth   = (W+1)'(1 << W);
    localparam logic [W:0]   c_af_lvl  = (W+1)'(AF_LVL);
    localparam logic [W:0]   c_ae_lvl  = (W+1)'(AE_LVL);
    localparam logic [W:0]   c_cnt_one = (W+1)'(1);
    localparam logic [W-1:0] c_ptr_one = W'(1);

    logic [W-1:0] r_wptr;
    logic [W-1:0] r_rptr;
    logic [W:0]   r_count;
    logic         r_ovf;
    logic         r_udf;

    logic         w_full;
    logic         w_empty;
    logic         w_push_ok;
    logic         w_pop_ok;
    logic         w_ovf_evt;
    logic         w_udf_evt;

    // Level flags come only from the registered count; equal pointers alone
    // are ambiguous, the count tells full from empty.
    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);

    // A push into a full FIFO is still legal when a pop frees the head slot
    // in the same cycle; a pop from an empty FIFO is never legal.
    assign w_push_ok = wr & (~w_full | rd);
    assign w_pop_ok  = rd & ~w_empty;

    // Error events are the rejected requests
    assign w_ovf_evt = wr & w_full & ~rd;
    assign w_udf_evt = rd & w_empty;

    // Write and read pointers advance on accepted operations, wrapping mod D
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
        end
    end

    // Occupancy count: push-only increments, pop-only decrements
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_count <= '0;
        end else begin
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new error event takes priority over err_clr
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (err_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_udf_evt) begin
                r_udf <= 1'b1;
            end else if (err_clr) begin
                r_udf <= 1'b0;
            end
        end
    end

    assign wr_en        = w_push_ok;
    assign w_addr       = r_wptr;
    assign r_addr       = r_rptr;
    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_af_lvl);
    assign almost_empty = (r_count <= c_ae_lvl);
    assign ovf          = r_ovf;
    assign udf          = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_ctrl
//  Brief    : Scoreboard bench for fifo_ctrl (W=2, AF_LVL=3, AE_LVL=1) with a
//             4x8 register file model attached to the controller.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] din = 8'h00;

    logic       wr_en;
    logic [1:0] w_addr;
    logic [1:0] r_addr;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] count;
    logic       ovf;
    logic       udf;

    logic [7:0] mem [4];
    logic [7:0] r_data;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      name;
        bit         imm;
        logic       exp_wren;
        bit         chk_rd;
        logic [7:0] exp_rd;
        logic [2:0] cnt;
        logic [1:0] wa;
        logic [1:0] ra;
        logic       ovf;
        logic       udf;
    } item_t;

    item_t sb[$];

    fifo_ctrl #(.W(2), .AF_LVL(3), .AE_LVL(1)) dut (
        .clk          (clk),
        .clr          (clr),
        .wr           (wr),
        .rd           (rd),
        .err_clr      (err_clr),
        .wr_en        (wr_en),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .ovf          (ovf),
        .udf          (udf)
    );

    always #5 clk = ~clk;

    // Register file: written through the controller's strobe and address
    always @(posedge clk) begin
        if (wr_en) mem[w_addr] <= din;
    end
    assign r_data = mem[r_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue its expectation
    task automatic op(input string nm, input bit c, input bit w, input bit r, input bit e,
                      input logic [7:0] d, input bit imm, input logic exp_wren,
                      input bit chk_rd, input logic [7:0] exp_rd,
                      input logic [2:0] cnt, input logic [1:0] wa, input logic [1:0] ra,
                      input logic eo, input logic eu);
        item_t it;
        @(negedge clk);
        clr = c; wr = w; rd = r; err_clr = e; din = d;
        it.name = nm; it.imm = imm; it.exp_wren = exp_wren; it.chk_rd = chk_rd;
        it.exp_rd = exp_rd; it.cnt = cnt; it.wa = wa; it.ra = ra; it.ovf = eo; it.udf = eu;
        sb.push_back(it);
    endtask

    // Monitor: combinational outputs mid-cycle, registered state after the edge
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() != 0) begin
                it = sb.pop_front();
                chk({it.name, ".wr_en"}, 32'(wr_en), 32'(it.exp_wren));
                if (it.chk_rd) chk({it.name, ".r_data"}, 32'(r_data), 32'(it.exp_rd));
                if (!it.imm) begin
                    @(posedge clk);
                    #1;
                end
                chk({it.name, ".count"}, 32'(count), 32'(it.cnt));
                chk({it.name, ".w_addr"}, 32'(w_addr), 32'(it.wa));
                chk({it.name, ".r_addr"}, 32'(r_addr), 32'(it.ra));
                chk({it.name, ".full"}, 32'(full), 32'(it.cnt == 3'd4));
                chk({it.name, ".empty"}, 32'(empty), 32'(it.cnt == 3'd0));
                chk({it.name, ".almost_full"}, 32'(almost_full), 32'(it.cnt >= 3'd3));
                chk({it.name, ".almost_empty"}, 32'(almost_empty), 32'(it.cnt <= 3'd1));
                chk({it.name, ".ovf"}, 32'(ovf), 32'(it.ovf));
                chk({it.name, ".udf"}, 32'(udf), 32'(it.udf));
            end
        end
    end

    // Directed vectors:  name  clr wr rd ec din imm wren chk exp  cnt wa ra ovf udf
    initial begin
        op("rst",        1,0,0,0,8'h00, 1, 0, 0,8'h00, 3'd0,2'd0,2'd0, 0,0);
        op("fill1",      0,1,0,0,8'h11, 0, 1, 0,8'h00, 3'd1,2'd1,2'd0, 0,0);
        op("fill2",      0,1,0,0,8'h22, 0, 1, 0,8'h00, 3'd2,2'd2,2'd0, 0,0);
        op("fill3",      0,1,0,0,8'h33, 0, 1, 0,8'h00, 3'd3,2'd3,2'd0, 0,0);
        op("fill4",      0,1,0,0,8'h44, 0, 1, 0,8'h00, 3'd4,2'd0,2'd0, 0,0);
        op("ovf",        0,1,0,0,8'h55, 0, 0, 0,8'h00, 3'd4,2'd0,2'd0, 1,0);
        op("ovf_hold",   0,0,0,0,8'h00, 0, 0, 0,8'h00, 3'd4,2'd0,2'd0, 1,0);
        op("ovf_vs_clr", 0,1,0,1,8'h56, 0, 0, 0,8'h00, 3'd4,2'd0,2'd0, 1,0);
        op("ovf_clr",    0,0,0,1,8'h00, 0, 0, 0,8'h00, 3'd4,2'd0,2'd0, 0,0);
        op("drain1",     0,0,1,0,8'h00, 0, 0, 1,8'h11, 3'd3,2'd0,2'd1, 0,0);
        op("drain2",     0,0,1,0,8'h00, 0, 0, 1,8'h22, 3'd2,2'd0,2'd2, 0,0);
        op("drain3",     0,0,1,0,8'h00, 0, 0, 1,8'h33, 3'd1,2'd0,2'd3, 0,0);
        op("drain4",     0,0,1,0,8'h00, 0, 0, 1,8'h44, 3'd0,2'd0,2'd0, 0,0);
        op("udf",        0,0,1,0,8'h00, 0, 0, 0,8'h00, 3'd0,2'd0,2'd0, 0,1);
        op("udf_clr",    0,0,0,1,8'h00, 0, 0, 0,8'h00, 3'd0,2'd0,2'd0, 0,0);
        op("simul_empty",0,1,1,0,8'h77, 0, 1, 0,8'h00, 3'd1,2'd1,2'd0, 0,1);
        op("push88",     0,1,0,0,8'h88, 0, 1, 0,8'h00, 3'd2,2'd2,2'd0, 0,1);
        op("push99",     0,1,0,0,8'h99, 0, 1, 0,8'h00, 3'd3,2'd3,2'd0, 0,1);
        op("pushAA",     0,1,0,0,8'hAA, 0, 1, 0,8'h00, 3'd4,2'd0,2'd0, 0,1);
        op("simul_full", 0,1,1,0,8'hBB, 0, 1, 1,8'h77, 3'd4,2'd1,2'd1, 0,1);
        op("pop_ec",     0,0,1,1,8'h00, 0, 0, 1,8'h88, 3'd3,2'd1,2'd2, 0,0);
        op("pushCC",     0,1,0,0,8'hCC, 0, 1, 0,8'h00, 3'd4,2'd2,2'd2, 0,0);
        op("ovf2",       0,1,0,0,8'hDD, 0, 0, 0,8'h00, 3'd4,2'd2,2'd2, 1,0);
        op("pop99",      0,0,1,0,8'h00, 0, 0, 1,8'h99, 3'd3,2'd2,2'd3, 1,0);
        op("popAA",      0,0,1,0,8'h00, 0, 0, 1,8'hAA, 3'd2,2'd2,2'd0, 1,0);
        op("async_rst",  1,0,0,0,8'h00, 1, 0, 0,8'h00, 3'd0,2'd0,2'd0, 0,0);
        op("rel_push",   0,1,0,0,8'hEE, 0, 1, 0,8'h00, 3'd1,2'd1,2'd0, 0,0);
        op("popEE",      0,0,1,0,8'h00, 0, 0, 1,8'hEE, 3'd0,2'd1,2'd1, 0,0);
        @(negedge clk);
        wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
